// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader, CPU and instruction RAM.
package loader_pkg;

    localparam int unsigned LOADER_ADDR_W = 8;
    localparam int unsigned LOADER_DATA_W = 8;
    localparam logic [7:0]  LOADER_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/imem_loader.sv
// Framed byte-stream loader: writes program bytes into instruction RAM and
// holds the CPU in reset until a frame with a good XOR checksum has landed.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned          ADDR_W    = LOADER_ADDR_W,
    parameter int unsigned          DATA_W    = LOADER_DATA_W,
    parameter logic [DATA_W-1:0]    SYNC_BYTE = DATA_W'(LOADER_SYNC_BYTE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] prog_len
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   counter_q, counter_d;
    logic [DATA_W-1:0]   csum_q, csum_d;
    logic [ADDR_W-1:0]   prog_len_q, prog_len_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                in_ready_q, in_ready_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                accept;

    assign accept = in_valid && in_ready_q;

    // Next-state, datapath updates and registered-output decode of the next state.
    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        csum_d      = csum_q;
        prog_len_d  = prog_len_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept && (in_data == SYNC_BYTE)) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    if (in_data == '0) begin
                        state_d = ST_ERR;
                    end else begin
                        prog_len_d = ADDR_W'(in_data);
                        counter_d  = '0;
                        csum_d     = '0;
                        mem_addr_d = '0;
                        state_d    = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = counter_q;
                    mem_wdata_d = in_data;
                    csum_d      = csum_q ^ in_data;
                    counter_d   = counter_q + ADDR_W'(1);
                    if (counter_q == (prog_len_q - ADDR_W'(1))) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
                end
            end
            ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d  = (state_d != ST_DONE) && (state_d != ST_ERR);
        busy_d      = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CSUM);
        done_d      = (state_d == ST_DONE);
        err_d       = (state_d == ST_ERR);
        cpu_reset_d = (state_d != ST_DONE);
    end

    // State and output registers; async active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            counter_q   <= '0;
            csum_q      <= '0;
            prog_len_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            in_ready_q  <= 1'b1;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            csum_q      <= csum_d;
            prog_len_q  <= prog_len_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            in_ready_q  <= in_ready_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_reset = cpu_reset_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign prog_len  = prog_len_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: per-cycle vector table plus directed sequences.
module tb_imem_loader;

    logic       clk;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_reset;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] prog_len;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ram [0:255];

    imem_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .prog_len  (prog_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External instruction RAM model, written through the loader port.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    typedef struct packed {
        logic       start;
        logic       valid;
        logic [7:0] data;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       ready;
        logic       busy;
        logic       done;
        logic       err;
        logic       cpu_rst;
        logic [7:0] plen;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic v, input logic [7:0] d,
                       input logic we, input logic [7:0] a, input logic [7:0] wd,
                       input logic rdy, input logic bsy, input logic dn, input logic er,
                       input logic cr, input logic [7:0] pl);
        vec_t t;
        t.start = s; t.valid = v; t.data = d;
        t.we = we; t.addr = a; t.wdata = wd;
        t.ready = rdy; t.busy = bsy; t.done = dn; t.err = er;
        t.cpu_rst = cr; t.plen = pl;
        vecs.push_back(t);
    endtask

    // Drive one cycle of inputs and sample just after the rising edge.
    task automatic cyc(input logic s, input logic v, input logic [7:0] d);
        start = s; in_valid = v; in_data = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [35:0] pack_out(input logic we, input logic [7:0] a,
                                             input logic [7:0] wd, input logic rdy,
                                             input logic bsy, input logic dn, input logic er,
                                             input logic cr, input logic [7:0] pl);
        // Address/data only matter while the strobe is up.
        return {we, (we ? a : 8'h00), (we ? wd : 8'h00), rdy, bsy, dn, er, cr, pl, 3'b000};
    endfunction

    logic [7:0] x;
    logic [7:0] wexp;

    initial begin
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #12;
        check("reset_outputs",
              64'(pack_out(mem_we, mem_addr, mem_wdata, in_ready, busy, done, err, cpu_reset, prog_len)),
              64'(pack_out(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00)));
        check("reset_addr_data", 64'({mem_addr, mem_wdata}), 64'(16'h0000));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Good frame A5,03,10,21,F0,C1
        add(0,1,8'hA5, 0,8'h00,8'h00, 1,1,0,0,1,8'h00);
        add(0,1,8'h03, 0,8'h00,8'h00, 1,1,0,0,1,8'h03);
        add(0,1,8'h10, 1,8'h00,8'h10, 1,1,0,0,1,8'h03);
        add(0,1,8'h21, 1,8'h01,8'h21, 1,1,0,0,1,8'h03);
        add(0,1,8'hF0, 1,8'h02,8'hF0, 1,1,0,0,1,8'h03);
        add(0,1,8'hC1, 0,8'h00,8'h00, 0,0,1,0,0,8'h03);
        add(0,0,8'h00, 0,8'h00,8'h00, 0,0,1,0,0,8'h03);
        add(1,0,8'h00, 0,8'h00,8'h00, 1,0,0,0,1,8'h03);
        // Bad checksum A5,02,11,22,00
        add(0,1,8'hA5, 0,8'h00,8'h00, 1,1,0,0,1,8'h03);
        add(0,1,8'h02, 0,8'h00,8'h00, 1,1,0,0,1,8'h02);
        add(0,1,8'h11, 1,8'h00,8'h11, 1,1,0,0,1,8'h02);
        add(0,1,8'h22, 1,8'h01,8'h22, 1,1,0,0,1,8'h02);
        add(0,1,8'h00, 0,8'h00,8'h00, 0,0,0,1,1,8'h02);
        add(0,1,8'hA5, 0,8'h00,8'h00, 0,0,0,1,1,8'h02);
        add(1,0,8'h00, 0,8'h00,8'h00, 1,0,0,0,1,8'h02);
        // Junk before sync 00,FF,A5,01,7E,7E
        add(0,1,8'h00, 0,8'h00,8'h00, 1,0,0,0,1,8'h02);
        add(0,1,8'hFF, 0,8'h00,8'h00, 1,0,0,0,1,8'h02);
        add(0,1,8'hA5, 0,8'h00,8'h00, 1,1,0,0,1,8'h02);
        add(0,1,8'h01, 0,8'h00,8'h00, 1,1,0,0,1,8'h01);
        add(0,1,8'h7E, 1,8'h00,8'h7E, 1,1,0,0,1,8'h01);
        add(0,1,8'h7E, 0,8'h00,8'h00, 0,0,1,0,0,8'h01);
        add(1,0,8'h00, 0,8'h00,8'h00, 1,0,0,0,1,8'h01);
        // LEN=0 frame A5,00
        add(0,1,8'hA5, 0,8'h00,8'h00, 1,1,0,0,1,8'h01);
        add(0,1,8'h00, 0,8'h00,8'h00, 0,0,0,1,1,8'h01);
        add(0,0,8'h00, 0,8'h00,8'h00, 0,0,0,1,1,8'h01);
        add(1,0,8'h00, 0,8'h00,8'h00, 1,0,0,0,1,8'h01);

        foreach (vecs[i]) begin
            cyc(vecs[i].start, vecs[i].valid, vecs[i].data);
            check($sformatf("vec[%0d]", i),
                  64'(pack_out(mem_we, mem_addr, mem_wdata, in_ready, busy, done, err, cpu_reset, prog_len)),
                  64'(pack_out(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ready, vecs[i].busy,
                               vecs[i].done, vecs[i].err, vecs[i].cpu_rst, vecs[i].plen)));
            if (i == 5) check("fetch_pc0_good", 64'(ram[0]), 64'(8'h10));
        end

        // Backpressure: A5,02,33,44,77 with 3 idle cycles between bytes.
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: x = 8'hA5; 1: x = 8'h02; 2: x = 8'h33; 3: x = 8'h44; default: x = 8'h77;
            endcase
            cyc(1'b0, 1'b1, x);
            check($sformatf("bp_we_hs%0d", i), 64'(mem_we), 64'((i == 2 || i == 3) ? 1 : 0));
            if (i == 2 || i == 3) check($sformatf("bp_addr%0d", i), 64'(mem_addr), 64'(i - 2));
            if (i < 4) begin
                for (int g = 0; g < 3; g++) begin
                    cyc(1'b0, 1'b0, 8'hEE);
                    check($sformatf("bp_gap%0d_%0d", i, g), 64'({mem_we, done}), 64'(2'b00));
                end
            end
        end
        check("bp_done", 64'({done, err, cpu_reset, in_ready}), 64'(4'b1000));
        cyc(1'b0, 1'b1, 8'h5A);
        cyc(1'b0, 1'b1, 8'h5A);
        check("bp_no_consume", 64'({done, in_ready, busy, mem_we, prog_len}), 64'({4'b1000, 8'h02}));
        check("bp_ram", 64'({ram[0], ram[1]}), 64'(16'h3344));
        cyc(1'b1, 1'b0, 8'h00);

        // LEN=255 boundary: addresses 0..254, no wrap.
        cyc(1'b0, 1'b1, 8'hA5);
        cyc(1'b0, 1'b1, 8'hFF);
        wexp = 8'h00;
        for (int i = 0; i < 255; i++) begin
            cyc(1'b0, 1'b1, 8'(i));
            wexp = wexp ^ 8'(i);
            if (mem_we !== 1'b1 || mem_addr !== 8'(i)) begin
                check($sformatf("len255_addr%0d", i), 64'({mem_we, mem_addr}), 64'({1'b1, 8'(i)}));
            end
        end
        check("len255_last_addr", 64'({mem_we, mem_addr, busy}), 64'({1'b1, 8'hFE, 1'b1}));
        cyc(1'b0, 1'b1, wexp);
        check("len255_done", 64'({done, mem_we, prog_len}), 64'({2'b10, 8'hFF}));
        cyc(1'b1, 1'b0, 8'h00);

        // Reset mid-frame after A5,04,AA.
        cyc(1'b0, 1'b1, 8'hA5);
        cyc(1'b0, 1'b1, 8'h04);
        cyc(1'b0, 1'b1, 8'hAA);
        cyc(1'b0, 1'b0, 8'h00);
        reset = 1'b0;
        #1;
        check("midrst_async",
              64'({cpu_reset, busy, in_ready, mem_we, done, err, prog_len}),
              64'({6'b101000, 8'h00}));
        check("midrst_ram_kept", 64'(ram[0]), 64'(8'hAA));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b1, 8'hA5);
        cyc(1'b0, 1'b1, 8'h01);
        cyc(1'b0, 1'b1, 8'h55);
        check("midrst_write", 64'({mem_we, mem_addr, mem_wdata}), 64'({1'b1, 8'h00, 8'h55}));
        cyc(1'b0, 1'b1, 8'h55);
        check("midrst_done", 64'({done, err, cpu_reset, prog_len}), 64'({3'b100, 8'h01}));
        check("midrst_fetch", 64'(ram[0]), 64'(8'h55));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface that the CPU fetches from.
- Accepts a framed byte stream over a valid/ready handshake and writes program bytes into a writable instruction RAM starting at address 0.
- Holds the CPU in reset until a complete frame with a good checksum has been loaded, then releases it.
- Sits between the host/UART byte source and the instr RAM write port; drives the CPU's active-high reset.

Parameters:
- ADDR_W, 8, instruction-memory address width (matches CPU pc width).
- DATA_W, 8, instruction byte width.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-low (0 = in reset).
- start  in  1  one-cycle pulse; in DONE or ERR, re-arms the loader.
- in_valid  in  1  source has a byte on in_data.
- in_data  in  DATA_W  stream byte.
- in_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  instruction RAM write enable, one cycle per program byte.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  DATA_W  write data.
- cpu_reset  out  1  active-high reset to the CPU.
- busy  out  1  frame in progress (LEN, DATA or CSUM states).
- done  out  1  load succeeded; level output.
- err  out  1  load failed; level output.
- prog_len  out  ADDR_W  LEN of the last accepted frame.

Behaviour:
- Reset (reset=0, async) values:
  - State IDLE; in_ready=1.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_reset=1, busy=0, done=0, err=0, prog_len=0.
  - Byte counter and checksum cleared.
- Handshake:
  - A byte is accepted on a rising edge where in_valid && in_ready.
  - in_data must be stable while in_valid=1 && in_ready=0.
- Frame format: SYNC_BYTE, LEN (1..255), LEN program bytes, CSUM. CSUM is the XOR of all program bytes.
- FSM states: IDLE, LEN, DATA, CSUM, DONE, ERR.
  - IDLE (in_ready=1): accepted byte == SYNC_BYTE -> LEN. Any other byte is discarded; stay in IDLE.
  - LEN (in_ready=1): accepted byte == 0 -> ERR. Otherwise prog_len <= byte, counter <= 0, csum <= 0, go to DATA.
  - DATA (in_ready=1): on each accept:
    - mem_we=1, mem_addr=counter, mem_wdata=byte are all registered and asserted for exactly the following cycle.
    - csum ^= byte; counter++.
    - Accept with counter == prog_len-1 -> CSUM.
  - CSUM (in_ready=1): accepted byte == csum -> DONE; otherwise -> ERR.
  - DONE: in_ready=0, done=1, cpu_reset=0 (deasserts the cycle after the CSUM accept).
  - ERR: in_ready=0, err=1, cpu_reset=1.
  - DONE or ERR with start=1 -> IDLE. done and err clear, cpu_reset=1 from the next cycle. start is ignored in all other states.
- Latency:
  - Write strobe 1 cycle after the byte handshake.
  - Full frame throughput is 1 byte/cycle when in_valid is held high.
- Flag rules:
  - busy=1 exactly in LEN, DATA and CSUM.
  - done and err are mutually exclusive.
- Address rules:
  - mem_addr never exceeds prog_len-1.
  - LEN=255 writes addresses 0..254; no wrap.
- Reset mid-frame:
  - Immediate return to IDLE with cpu_reset=1.
  - Bytes already written to RAM are not erased; a new full frame is required.
- in_valid deasserted mid-frame: the loader waits indefinitely in the current state (no timeout).

Decomposition:
- Shared package loader_pkg holds:
  - State enum (IDLE, LEN, DATA, CSUM, DONE, ERR).
  - SYNC_BYTE constant.
  - ADDR_W/DATA_W defaults shared with the CPU and instr RAM.
- Single flat FSM module; no sub-module is warranted.
- Instruction RAM is external (dual-port: loader writes, CPU reads via pc).

Test Plan:
- Good frame: stream A5,03,10,21,F0,C1 with in_valid held.
  - Required writes: addr0=10, addr1=21, addr2=F0 on consecutive cycles.
  - Then done=1, cpu_reset=0, prog_len=3; CPU then fetches 10 at pc=0.
- Bad checksum: A5,02,11,22,00.
  - Both bytes are written.
  - Then err=1, done=0, cpu_reset stays 1, in_ready=0.
  - start pulse -> IDLE, err=0, in_ready=1.
- Junk before sync: 00,FF,A5,01,7E,7E.
  - No writes for 00/FF; addr0=7E; done=1.
- LEN=0: A5,00 -> err=1; mem_we never asserted.
- Backpressure/gaps: A5,02,33,44,77 with in_valid low for 3 cycles between bytes.
  - Writes occur only after each handshake; done=1.
  - in_ready=0 after done, and a further valid byte is not consumed.
- Reset mid-frame: reset=0 after A5,04,AA.
  - Outputs take reset values asynchronously (cpu_reset=1, busy=0).
  - After release, a full frame A5,01,55,55 -> done=1, addr0=55.
